sdram_timer: RTL and testbench



---
 rtl/sdram_timer_pkg.sv | 57 +++++
 rtl/sdram_timer_if.sv | 41 ++++
 rtl/sdram_timer_ref_gen.sv | 64 ++++++
 rtl/sdram_timer.sv | 102 ++++++++++
 tb/tb_sdram_timer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/sdram_timer_pkg.sv
// Shared SDRAM controller state codes and default JEDEC timing constants.
package sdram_timer_pkg;

  // Default timing, in controller clock cycles (133 MHz).
  localparam int unsigned T_200US_DEF    = 26600;
  localparam int unsigned TRP_CLK_DEF    = 3;
  localparam int unsigned TRFC_CLK_DEF   = 9;
  localparam int unsigned TMRD_CLK_DEF   = 2;
  localparam int unsigned TRCD_CLK_DEF   = 3;
  localparam int unsigned TCL_CLK_DEF    = 2;
  localparam int unsigned TREAD_CLK_DEF  = 4;
  localparam int unsigned TWAIT_CLK_DEF  = 3;
  localparam int unsigned TWRITE_CLK_DEF = 4;
  localparam int unsigned TDAL_CLK_DEF   = 5;
  localparam int unsigned REF_PERIOD_DEF = 1040;
  localparam int unsigned REF_GUARD_DEF  = 16;

  // Init-FSM state codes; I_NOP is the reset state.
  typedef enum logic [4:0] {
    I_NOP      = 5'd0,
    I_PRE      = 5'd1,
    I_PRE_TRP  = 5'd2,
    I_AR0      = 5'd3,
    I_AR0_TRFC = 5'd4,
    I_AR1      = 5'd5,
    I_AR1_TRFC = 5'd6,
    I_MRS      = 5'd7,
    I_MRS_TMRD = 5'd8,
    I_DONE     = 5'd9
  } init_state_e;

  // Work-FSM state codes; S_IDLE is the reset state.
  typedef enum logic [4:0] {
    S_IDLE       = 5'd0,
    S_NOP        = 5'd1,
    S_REF        = 5'd2,
    S_TRFC       = 5'd3,
    S_REF1       = 5'd4,
    S_TRFC1      = 5'd5,
    S_RAS_ACTIVE = 5'd6,
    S_TRCD       = 5'd7,
    S_RD_CMD     = 5'd8,
    S_CL         = 5'd9,
    S_RD_DATA    = 5'd10,
    S_RWAIT      = 5'd11,
    S_WR_CMD     = 5'd12,
    S_WR_DATA    = 5'd13,
    S_TDAL       = 5'd14
  } work_state_e;

  // True once a state has been occupied for its full wait of t cycles
  // (dwell counts from 0 on the first cycle in the state).
  function automatic logic wait_done(input logic [15:0] dwell, input int unsigned t);
    return ({16'b0, dwell} + 32'd1) >= t;
  endfunction

endpackage

// File: rtl/sdram_timer_if.sv
// Core <-> timer signal bundle. ref_overflow exists only with SDRAM_TIMER_REF_OVF_EN.
interface sdram_timer_if;
  logic [4:0] init_state;
  logic [4:0] work_state;
  logic       sdram_ref_ack;
  logic       done_200us;
  logic       end_trp;
  logic       end_trfc;
  logic       end_tmrd;
  logic       end_trcd;
  logic       end_tcl;
  logic       end_tread;
  logic       end_twait;
  logic       end_twrite;
  logic       end_tdal;
  logic       sdram_ref_req;
  logic       ref_domain;
`ifdef SDRAM_TIMER_REF_OVF_EN
  logic       ref_overflow;
`endif

  // Core side
  modport master (
    output init_state, work_state, sdram_ref_ack,
    input  done_200us, end_trp, end_trfc, end_tmrd, end_trcd, end_tcl,
           end_tread, end_twait, end_twrite, end_tdal, sdram_ref_req, ref_domain
`ifdef SDRAM_TIMER_REF_OVF_EN
    , input ref_overflow
`endif
  );

  // Timer side
  modport slave (
    input  init_state, work_state, sdram_ref_ack,
    output done_200us, end_trp, end_trfc, end_tmrd, end_trcd, end_tcl,
           end_tread, end_twait, end_twrite, end_tdal, sdram_ref_req, ref_domain
`ifdef SDRAM_TIMER_REF_OVF_EN
    , output ref_overflow
`endif
  );
endinterface

// File: rtl/sdram_timer_ref_gen.sv
// Auto-refresh interval counter, req/ack handshake and refresh window.
// SDRAM_TIMER_REF_OVF_EN adds a sticky overflow flag for a starved refresh.
module sdram_ref_gen #(
  parameter int unsigned REF_PERIOD = 1040,
  parameter int unsigned REF_GUARD  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic ack,
  output logic req,
  output logic ref_domain
`ifdef SDRAM_TIMER_REF_OVF_EN
  , output logic ref_overflow
`endif
);
  localparam int unsigned RC_W = $clog2(REF_PERIOD);

  logic [RC_W-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            expiry;
`ifdef SDRAM_TIMER_REF_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  // Next-state: free-running interval counter; a new request beats a same-cycle ack
  always_comb begin
    cnt_d  = cnt_q;
    req_d  = req_q;
    expiry = run && (32'(cnt_q) == REF_PERIOD - 1);
    if (!run)        cnt_d = '0;
    else if (expiry) cnt_d = '0;
    else             cnt_d = cnt_q + RC_W'(1);
    if (expiry)      req_d = 1'b1;
    else if (ack)    req_d = 1'b0;
`ifdef SDRAM_TIMER_REF_OVF_EN
    ovf_d = ovf_q | (expiry & req_q & ~ack);
`endif
  end

  // Registers, synchronously cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      req_q <= 1'b0;
`ifdef SDRAM_TIMER_REF_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      req_q <= req_d;
`ifdef SDRAM_TIMER_REF_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign req        = req_q;
  assign ref_domain = req_q || (32'(cnt_q) >= REF_PERIOD - REF_GUARD);
`ifdef SDRAM_TIMER_REF_OVF_EN
  assign ref_overflow = ovf_q;
`endif

endmodule

// File: rtl/sdram_timer.sv
// SDRAM timing/refresh generator: power-up wait, per-state dwell strobes,
// and refresh request (sdram_ref_gen). SDRAM_TIMER_REF_OVF_EN enables ref_overflow.
module sdram_timer
  import sdram_timer_pkg::*;
#(
  parameter int unsigned T_200US    = T_200US_DEF,
  parameter int unsigned TRP_CLK    = TRP_CLK_DEF,
  parameter int unsigned TRFC_CLK   = TRFC_CLK_DEF,
  parameter int unsigned TMRD_CLK   = TMRD_CLK_DEF,
  parameter int unsigned TRCD_CLK   = TRCD_CLK_DEF,
  parameter int unsigned TCL_CLK    = TCL_CLK_DEF,
  parameter int unsigned TREAD_CLK  = TREAD_CLK_DEF,
  parameter int unsigned TWAIT_CLK  = TWAIT_CLK_DEF,
  parameter int unsigned TWRITE_CLK = TWRITE_CLK_DEF,
  parameter int unsigned TDAL_CLK   = TDAL_CLK_DEF,
  parameter int unsigned REF_PERIOD = REF_PERIOD_DEF,
  parameter int unsigned REF_GUARD  = REF_GUARD_DEF
) (
  input logic         clk,
  input logic         rst,
  sdram_timer_if.slave bus
);
  localparam int unsigned PU_W = $clog2(T_200US);

  logic [PU_W-1:0] pu_cnt_q, pu_cnt_d;
  logic            done_q, done_d;
  logic [9:0]      prev_state_q, prev_state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [9:0]      cur_state;
  logic            state_chg;
  logic [15:0]     dwell;

  assign cur_state = {bus.init_state, bus.work_state};
  assign state_chg = cur_state != prev_state_q;
  assign dwell     = state_chg ? 16'd0 : cnt_q;

  // Power-up counter: stops once the sticky done flag is set
  always_comb begin
    pu_cnt_d = pu_cnt_q;
    done_d   = done_q;
    if (!done_q) begin
      pu_cnt_d = pu_cnt_q + PU_W'(1);
      if (32'(pu_cnt_d) == T_200US - 1) done_d = 1'b1;
    end
  end

  // Dwell counter: restarts on any change of the combined state code, saturates
  always_comb begin
    prev_state_d = cur_state;
    cnt_d        = cnt_q;
    if (state_chg)        cnt_d = 16'd1;
    else if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
  end

  // Registers, synchronously cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      pu_cnt_q     <= '0;
      done_q       <= 1'b0;
      prev_state_q <= '0;
      cnt_q        <= '0;
    end else begin
      pu_cnt_q     <= pu_cnt_d;
      done_q       <= done_d;
      prev_state_q <= prev_state_d;
      cnt_q        <= cnt_d;
    end
  end

  // Wait-complete strobes: held high while the wait state persists
  always_comb begin
    bus.end_trp    = (bus.init_state == I_PRE_TRP) && wait_done(dwell, TRP_CLK);
    bus.end_trfc   = ((bus.init_state == I_AR0_TRFC) || (bus.init_state == I_AR1_TRFC) ||
                      (bus.work_state == S_TRFC) || (bus.work_state == S_TRFC1)) &&
                     wait_done(dwell, TRFC_CLK);
    bus.end_tmrd   = (bus.init_state == I_MRS_TMRD) && wait_done(dwell, TMRD_CLK);
    bus.end_trcd   = (bus.work_state == S_TRCD)     && wait_done(dwell, TRCD_CLK);
    bus.end_tcl    = (bus.work_state == S_CL)       && wait_done(dwell, TCL_CLK);
    bus.end_tread  = (bus.work_state == S_RD_DATA)  && wait_done(dwell, TREAD_CLK);
    bus.end_twait  = (bus.work_state == S_RWAIT)    && wait_done(dwell, TWAIT_CLK);
    bus.end_twrite = (bus.work_state == S_WR_DATA)  && wait_done(dwell, TWRITE_CLK);
    bus.end_tdal   = (bus.work_state == S_TDAL)     && wait_done(dwell, TDAL_CLK);
  end

  assign bus.done_200us = done_q;

  sdram_ref_gen #(
    .REF_PERIOD (REF_PERIOD),
    .REF_GUARD  (REF_GUARD)
  ) u_ref_gen (
    .clk          (clk),
    .rst          (rst),
    .run          (bus.init_state == I_DONE),
    .ack          (bus.sdram_ref_ack),
    .req          (bus.sdram_ref_req),
    .ref_domain   (bus.ref_domain)
`ifdef SDRAM_TIMER_REF_OVF_EN
    , .ref_overflow (bus.ref_overflow)
`endif
  );

endmodule

// File: tb/tb_sdram_timer.sv
// Directed self-checking bench for sdram_timer.
module tb_sdram_timer;
  import sdram_timer_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  sdram_timer_if bus();

  sdram_timer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [8:0] B_TRP    = 9'h100;
  localparam logic [8:0] B_TRFC   = 9'h080;
  localparam logic [8:0] B_TMRD   = 9'h040;
  localparam logic [8:0] B_TRCD   = 9'h020;
  localparam logic [8:0] B_TCL    = 9'h010;
  localparam logic [8:0] B_TREAD  = 9'h008;
  localparam logic [8:0] B_TWAIT  = 9'h004;
  localparam logic [8:0] B_TWRITE = 9'h002;
  localparam logic [8:0] B_TDAL   = 9'h001;

  function automatic logic [8:0] strb();
    return {bus.end_trp, bus.end_trfc, bus.end_tmrd, bus.end_trcd, bus.end_tcl,
            bus.end_tread, bus.end_twait, bus.end_twrite, bus.end_tdal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a state for n cycles; the strobe bit is expected from cycle t-1 on (t=0: never)
  task automatic run_state(input logic [4:0] is, input logic [4:0] ws, input int n,
                           input int t, input logic [8:0] bitv, input string tag);
    bus.init_state = is;
    bus.work_state = ws;
    for (int k = 0; k < n; k++) begin
      #1;
      chk($sformatf("%s[%0d]", tag, k), 32'(strb()),
          32'((t > 0 && k >= t - 1) ? bitv : 9'h000));
      tick();
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.init_state    = I_NOP;
    bus.work_state    = S_IDLE;
    bus.sdram_ref_ack = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_done", 32'(bus.done_200us), 32'd0);
    chk("rst_req",  32'(bus.sdram_ref_req), 32'd0);
    chk("rst_dom",  32'(bus.ref_domain), 32'd0);
    chk("rst_strb", 32'(strb()), 32'd0);
`ifdef SDRAM_TIMER_REF_OVF_EN
    chk("rst_ovf",  32'(bus.ref_overflow), 32'd0);
`endif

    // Power-up wait: done rises after the 26599th clock out of reset
    rst = 1'b0;
    for (int i = 0; i < 26598; i++) tick();
    chk("pu_26598", 32'(bus.done_200us), 32'd0);
    tick();
    chk("pu_26599", 32'(bus.done_200us), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pu_sticky", 32'(bus.done_200us), 32'd1);
    end
    rst = 1'b1;
    tick();
    chk("pu_rst", 32'(bus.done_200us), 32'd0);
    rst = 1'b0;

    // Init sequence
    run_state(I_NOP,      S_IDLE, 3, 0, 9'h0,   "i_nop");
    run_state(I_PRE,      S_IDLE, 1, 0, 9'h0,   "i_pre");
    run_state(I_PRE_TRP,  S_IDLE, 3, 3, B_TRP,  "i_trp");
    run_state(I_AR0,      S_IDLE, 1, 0, 9'h0,   "i_ar0");
    run_state(I_AR0_TRFC, S_IDLE, 9, 9, B_TRFC, "i_ar0_trfc");
    run_state(I_AR1,      S_IDLE, 1, 0, 9'h0,   "i_ar1");
    run_state(I_AR1_TRFC, S_IDLE, 11, 9, B_TRFC, "i_ar1_trfc_stall");
    run_state(I_MRS,      S_IDLE, 1, 0, 9'h0,   "i_mrs");
    run_state(I_MRS_TMRD, S_IDLE, 2, 2, B_TMRD, "i_tmrd");

    // Read path, CL stalled 5 extra cycles
    run_state(I_DONE, S_IDLE,       2, 0, 9'h0,    "s_idle");
    run_state(I_DONE, S_NOP,        1, 0, 9'h0,    "s_nop");
    run_state(I_DONE, S_RAS_ACTIVE, 1, 0, 9'h0,    "s_act");
    run_state(I_DONE, S_TRCD,       3, 3, B_TRCD,  "s_trcd");
    run_state(I_DONE, S_RD_CMD,     1, 0, 9'h0,    "s_rdcmd");
    run_state(I_DONE, S_CL,         7, 2, B_TCL,   "s_cl_stall");
    run_state(I_DONE, S_RD_DATA,    4, 4, B_TREAD, "s_rdata");
    run_state(I_DONE, S_RWAIT,      3, 3, B_TWAIT, "s_rwait");

    // Write then read back-to-back, including a direct wait-to-wait change
    run_state(I_DONE, S_WR_CMD,     1, 0, 9'h0,     "s_wrcmd");
    run_state(I_DONE, S_WR_DATA,    4, 4, B_TWRITE, "s_wdata");
    run_state(I_DONE, S_TDAL,       5, 5, B_TDAL,   "s_tdal");
    run_state(I_DONE, S_TRCD,       3, 3, B_TRCD,   "s_trcd2");
    run_state(I_DONE, S_RD_CMD,     1, 0, 9'h0,     "s_rdcmd2");
    run_state(I_DONE, S_CL,         2, 2, B_TCL,    "s_cl2");
    run_state(I_DONE, S_RD_DATA,    4, 4, B_TREAD,  "s_rdata2");

    // Refresh states: TRFC straight into TRFC1 must restart the shared strobe
    run_state(I_DONE, S_REF,        1, 0, 9'h0,   "s_ref");
    run_state(I_DONE, S_TRFC,       9, 9, B_TRFC, "s_trfc");
    run_state(I_DONE, S_TRFC1,      9, 9, B_TRFC, "s_trfc1");
    run_state(I_DONE, S_IDLE,       2, 0, 9'h0,   "s_idle2");

    // Refresh interval from a fresh reset; cycle 0 is the first cycle in I_DONE
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.init_state = I_DONE;
    bus.work_state = S_IDLE;
    for (int cyc = 0; cyc <= 3120; cyc++) begin
      bus.sdram_ref_ack = (cyc == 10) || (cyc == 1045) || (cyc == 3119);
      #1;
      case (cyc)
        0: begin
          chk("ref_c0_req", 32'(bus.sdram_ref_req), 32'd0);
          chk("ref_c0_dom", 32'(bus.ref_domain), 32'd0);
        end
        11:   chk("ref_stray_ack", 32'(bus.sdram_ref_req), 32'd0);
        1023: chk("ref_dom_1023", 32'(bus.ref_domain), 32'd0);
        1024: begin
          chk("ref_dom_1024", 32'(bus.ref_domain), 32'd1);
          chk("ref_req_1024", 32'(bus.sdram_ref_req), 32'd0);
        end
        1039: chk("ref_req_1039", 32'(bus.sdram_ref_req), 32'd0);
        1040: begin
          chk("ref_req_1040", 32'(bus.sdram_ref_req), 32'd1);
          chk("ref_dom_1040", 32'(bus.ref_domain), 32'd1);
        end
        1045: chk("ref_req_1045", 32'(bus.sdram_ref_req), 32'd1);
        1046: begin
          chk("ref_req_1046", 32'(bus.sdram_ref_req), 32'd0);
          chk("ref_dom_1046", 32'(bus.ref_domain), 32'd0);
        end
        2079: chk("ref_req_2079", 32'(bus.sdram_ref_req), 32'd0);
        2080: chk("ref_req_2080", 32'(bus.sdram_ref_req), 32'd1);
        3119: chk("ref_req_3119", 32'(bus.sdram_ref_req), 32'd1);
        3120: begin
          chk("ref_ack_vs_exp", 32'(bus.sdram_ref_req), 32'd1);
`ifdef SDRAM_TIMER_REF_OVF_EN
          chk("ovf_acked", 32'(bus.ref_overflow), 32'd0);
`endif
        end
        default: ;
      endcase
      tick();
    end
    bus.sdram_ref_ack = 1'b0;

`ifdef SDRAM_TIMER_REF_OVF_EN
    // Withhold ack across two expiries
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int cyc = 0; cyc <= 2110; cyc++) begin
      bus.sdram_ref_ack = (cyc == 2100);
      #1;
      case (cyc)
        1040: chk("ovf_1040", 32'(bus.ref_overflow), 32'd0);
        2079: chk("ovf_2079", 32'(bus.ref_overflow), 32'd0);
        2080: chk("ovf_2080", 32'(bus.ref_overflow), 32'd1);
        2101: begin
          chk("ovf_req_2101", 32'(bus.sdram_ref_req), 32'd0);
          chk("ovf_2101", 32'(bus.ref_overflow), 32'd1);
        end
        2110: chk("ovf_2110", 32'(bus.ref_overflow), 32'd1);
        default: ;
      endcase
      tick();
    end
    bus.sdram_ref_ack = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
